// File: rtl/dm_pkg.sv
// Debug-module shared definitions: DMI register addresses, dmcontrol /
// dmstatus / abstractcs / command field positions, cmderr codes, FSM state
// types and small helpers that assemble read-only register words.
package dm_pkg;

  // DMI register addresses
  localparam logic [6:0] ADDR_DATA0      = 7'h04;
  localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
  localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
  localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
  localparam logic [6:0] ADDR_COMMAND    = 7'h17;

  // dmcontrol bit positions
  localparam int unsigned DMC_HALTREQ   = 31;
  localparam int unsigned DMC_RESUMEREQ = 30;
  localparam int unsigned DMC_NDMRESET  = 1;
  localparam int unsigned DMC_DMACTIVE  = 0;

  // dmstatus fields
  localparam logic [3:0]  DMS_VERSION         = 4'd2;
  localparam int unsigned DMS_AUTHENTICATED   = 7;
  localparam int unsigned DMS_ANYHALTED       = 8;
  localparam int unsigned DMS_ALLHALTED       = 9;
  localparam int unsigned DMS_ANYRUNNING      = 10;
  localparam int unsigned DMS_ALLRUNNING      = 11;
  localparam int unsigned DMS_ANYRESUMEACK    = 16;
  localparam int unsigned DMS_ALLRESUMEACK    = 17;

  // abstractcs fields
  localparam logic [3:0]  ACS_DATACOUNT       = 4'd1;
  localparam int unsigned ACS_CMDERR_LSB      = 8;
  localparam int unsigned ACS_BUSY            = 12;
  localparam int unsigned ACS_PROGBUFSIZE_LSB = 24;

  // command fields
  localparam int unsigned CMD_TYPE_LSB   = 24;
  localparam int unsigned CMD_AARSIZE_LSB = 20;
  localparam int unsigned CMD_TRANSFER   = 17;
  localparam int unsigned CMD_WRITE      = 16;
  localparam logic [7:0]  CMDTYPE_ACCESS_REG = 8'd0;
  localparam logic [2:0]  AARSIZE_32         = 3'd2;

  typedef enum logic [2:0] {
    CMDERR_NONE       = 3'd0,
    CMDERR_BUSY       = 3'd1,
    CMDERR_NOTSUP     = 3'd2,
    CMDERR_HALTRESUME = 3'd4
  } cmderr_e;

  typedef enum logic [1:0] {
    H_IDLE,
    H_HALTING,
    H_RESUMING
  } hart_state_e;

  typedef enum logic {
    C_IDLE,
    C_EXEC
  } cmd_state_e;

  function automatic logic [31:0] dmstatus_word(input logic halted,
                                                input logic running,
                                                input logic resumeack);
    logic [31:0] w;
    w                    = '0;
    w[3:0]               = DMS_VERSION;
    w[DMS_AUTHENTICATED] = 1'b1;
    w[DMS_ANYHALTED]     = halted;
    w[DMS_ALLHALTED]     = halted;
    w[DMS_ANYRUNNING]    = running;
    w[DMS_ALLRUNNING]    = running;
    w[DMS_ANYRESUMEACK]  = resumeack;
    w[DMS_ALLRESUMEACK]  = resumeack;
    return w;
  endfunction

  function automatic logic [31:0] abstractcs_word(input logic [2:0] cmderr,
                                                  input logic       busy);
    logic [31:0] w;
    w                             = '0;
    w[3:0]                        = ACS_DATACOUNT;
    w[ACS_CMDERR_LSB +: 3]        = cmderr;
    w[ACS_BUSY]                   = busy;
    w[ACS_PROGBUFSIZE_LSB +: 5]   = 5'd0;
    return w;
  endfunction

endpackage

// File: rtl/dm_hart_ctrl.sv
// Minimal RISC-V style debug module for a single hart.
// Ports:
//   clk_i, reset_i            clock, asynchronous active-high reset
//   dmi_req_*                 one-cycle DMI request (addr, wr, wdata)
//   dmi_resp_valid_o/rdata_o  response one cycle after each request
//   dbg_haltreq_o/resumereq_o halt / resume requests to the core
//   ndmreset_o                system reset request (dmcontrol.ndmreset)
//   core_*_i                  halted / running / resumeack from the core
//   dbg_ar_*                  one-cycle abstract register access port
module dm_hart_ctrl
  import dm_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        dmi_req_valid_i,
  input  logic [6:0]  dmi_addr_i,
  input  logic        dmi_wr_i,
  input  logic [31:0] dmi_wdata_i,
  output logic        dmi_resp_valid_o,
  output logic [31:0] dmi_rdata_o,
  output logic        dbg_haltreq_o,
  output logic        dbg_resumereq_o,
  output logic        ndmreset_o,
  input  logic        core_halted_i,
  input  logic        core_running_i,
  input  logic        core_resumeack_i,
  output logic        dbg_ar_en_o,
  output logic        dbg_ar_wr_o,
  output logic [15:0] dbg_ar_ad_o,
  output logic [31:0] dbg_ar_do_o,
  input  logic [31:0] dbg_ar_di_i
);

  hart_state_e hart_q, hart_d;
  cmd_state_e  cmd_q,  cmd_d;

  logic        resp_valid_q;
  logic [31:0] rdata_q, rdata_d;
  logic        haltreq_q, haltreq_d;
  logic        resumereq_q, resumereq_d;
  logic        ndmreset_q, ndmreset_d;
  logic        dmactive_q, dmactive_d;
  logic        sticky_q, sticky_d;
  logic [31:0] data0_q, data0_d;
  logic [2:0]  cmderr_q, cmderr_d;
  logic        ar_wr_q, ar_wr_d;
  logic [15:0] ar_regno_q, ar_regno_d;

  logic wr_req, wr_dmcontrol, wr_data0, wr_abstractcs, wr_command;
  logic busy, active;
  logic unused_wdata;

  assign wr_req        = dmi_req_valid_i & dmi_wr_i;
  assign wr_dmcontrol  = wr_req & (dmi_addr_i == ADDR_DMCONTROL);
  assign wr_data0      = wr_req & (dmi_addr_i == ADDR_DATA0);
  assign wr_abstractcs = wr_req & (dmi_addr_i == ADDR_ABSTRACTCS);
  assign wr_command    = wr_req & (dmi_addr_i == ADDR_COMMAND);
  assign busy          = (cmd_q == C_EXEC);

  // The dmcontrol write that sets dmactive must itself take effect, so the
  // gate looks at the incoming value rather than the stored one.
  assign active = wr_dmcontrol ? dmi_wdata_i[DMC_DMACTIVE] : dmactive_q;

  // Reserved command bits carry no function.
  assign unused_wdata = ^{dmi_wdata_i[23], dmi_wdata_i[19:18]};

  always_comb begin
    hart_d      = hart_q;
    cmd_d       = C_IDLE;  // C_EXEC always lasts exactly one cycle
    haltreq_d   = haltreq_q;
    resumereq_d = resumereq_q;
    ndmreset_d  = ndmreset_q;
    dmactive_d  = dmactive_q;
    sticky_d    = sticky_q;
    data0_d     = data0_q;
    cmderr_d    = cmderr_q;
    ar_wr_d     = ar_wr_q;
    ar_regno_d  = ar_regno_q;

    if (busy && !ar_wr_q) begin
      data0_d = dbg_ar_di_i;
    end

    if (wr_dmcontrol) begin
      haltreq_d   = dmi_wdata_i[DMC_HALTREQ];
      resumereq_d = dmi_wdata_i[DMC_RESUMEREQ];
      ndmreset_d  = dmi_wdata_i[DMC_NDMRESET];
      dmactive_d  = dmi_wdata_i[DMC_DMACTIVE];
    end

    unique case (hart_q)
      H_IDLE: begin
        if (wr_dmcontrol) begin
          if (dmi_wdata_i[DMC_HALTREQ] && !core_halted_i) begin
            hart_d = H_HALTING;
          end else if (!dmi_wdata_i[DMC_HALTREQ] && dmi_wdata_i[DMC_RESUMEREQ] &&
                       core_halted_i) begin
            hart_d   = H_RESUMING;
            sticky_d = 1'b0;
          end
        end
      end
      H_HALTING: begin
        if (core_halted_i || (wr_dmcontrol && !dmi_wdata_i[DMC_HALTREQ])) begin
          hart_d = H_IDLE;
        end
      end
      H_RESUMING: begin
        if (core_resumeack_i) begin
          sticky_d = 1'b1;
          hart_d   = H_IDLE;
        end
      end
      default: hart_d = H_IDLE;
    endcase

    if (busy) begin
      if ((wr_data0 || wr_abstractcs || wr_command) && (cmderr_q == CMDERR_NONE)) begin
        cmderr_d = CMDERR_BUSY;
      end
    end else begin
      if (wr_data0) begin
        data0_d = dmi_wdata_i;
      end
      if (wr_abstractcs) begin
        cmderr_d = cmderr_q & ~dmi_wdata_i[ACS_CMDERR_LSB +: 3];
      end
      if (wr_command && (cmderr_q == CMDERR_NONE)) begin
        if ((dmi_wdata_i[CMD_TYPE_LSB +: 8] != CMDTYPE_ACCESS_REG) ||
            (dmi_wdata_i[CMD_AARSIZE_LSB +: 3] != AARSIZE_32)) begin
          cmderr_d = CMDERR_NOTSUP;
        end else if (!core_halted_i) begin
          cmderr_d = CMDERR_HALTRESUME;
        end else if (dmi_wdata_i[CMD_TRANSFER]) begin
          cmd_d      = C_EXEC;
          ar_wr_d    = dmi_wdata_i[CMD_WRITE];
          ar_regno_d = dmi_wdata_i[15:0];
        end
      end
    end

    // Inactive DM: everything except the response path returns to reset.
    if (!active) begin
      hart_d      = H_IDLE;
      cmd_d       = C_IDLE;
      haltreq_d   = 1'b0;
      resumereq_d = 1'b0;
      ndmreset_d  = 1'b0;
      dmactive_d  = 1'b0;
      sticky_d    = 1'b0;
      data0_d     = '0;
      cmderr_d    = CMDERR_NONE;
      ar_wr_d     = 1'b0;
      ar_regno_d  = '0;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (dmi_req_valid_i && !dmi_wr_i) begin
      case (dmi_addr_i)
        ADDR_DATA0:      rdata_d = data0_q;
        ADDR_DMCONTROL: begin
          rdata_d[DMC_HALTREQ]   = haltreq_q;
          rdata_d[DMC_RESUMEREQ] = resumereq_q;
          rdata_d[DMC_NDMRESET]  = ndmreset_q;
          rdata_d[DMC_DMACTIVE]  = dmactive_q;
        end
        ADDR_DMSTATUS:   rdata_d = dmstatus_word(core_halted_i, core_running_i, sticky_q);
        ADDR_ABSTRACTCS: rdata_d = abstractcs_word(cmderr_q, busy);
        default:         rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hart_q       <= H_IDLE;
      cmd_q        <= C_IDLE;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      haltreq_q    <= 1'b0;
      resumereq_q  <= 1'b0;
      ndmreset_q   <= 1'b0;
      dmactive_q   <= 1'b0;
      sticky_q     <= 1'b0;
      data0_q      <= '0;
      cmderr_q     <= CMDERR_NONE;
      ar_wr_q      <= 1'b0;
      ar_regno_q   <= '0;
    end else begin
      hart_q       <= hart_d;
      cmd_q        <= cmd_d;
      resp_valid_q <= dmi_req_valid_i;
      rdata_q      <= rdata_d;
      haltreq_q    <= haltreq_d;
      resumereq_q  <= resumereq_d;
      ndmreset_q   <= ndmreset_d;
      dmactive_q   <= dmactive_d;
      sticky_q     <= sticky_d;
      data0_q      <= data0_d;
      cmderr_q     <= cmderr_d;
      ar_wr_q      <= ar_wr_d;
      ar_regno_q   <= ar_regno_d;
    end
  end

  assign dmi_resp_valid_o = resp_valid_q;
  assign dmi_rdata_o      = rdata_q;
  assign dbg_haltreq_o    = (hart_q == H_HALTING);
  assign dbg_resumereq_o  = (hart_q == H_RESUMING);
  assign ndmreset_o       = ndmreset_q;
  assign dbg_ar_en_o      = busy;
  assign dbg_ar_wr_o      = busy & ar_wr_q;
  assign dbg_ar_ad_o      = busy ? ar_regno_q : '0;
  assign dbg_ar_do_o      = busy ? data0_q : '0;

endmodule

// File: tb/tb_dm_hart_ctrl.sv
// Bench for dm_hart_ctrl: directed scenarios followed by randomized DMI
// traffic and core behaviour, checked against a register-level model.
module tb_dm_hart_ctrl;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        dmi_req_valid_i;
  logic [6:0]  dmi_addr_i;
  logic        dmi_wr_i;
  logic [31:0] dmi_wdata_i;
  logic        dmi_resp_valid_o;
  logic [31:0] dmi_rdata_o;
  logic        dbg_haltreq_o, dbg_resumereq_o, ndmreset_o;
  logic        core_halted_i, core_running_i, core_resumeack_i;
  logic        dbg_ar_en_o, dbg_ar_wr_o;
  logic [15:0] dbg_ar_ad_o;
  logic [31:0] dbg_ar_do_o;
  logic [31:0] dbg_ar_di_i;

  dm_hart_ctrl dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .dmi_req_valid_i  (dmi_req_valid_i),
    .dmi_addr_i       (dmi_addr_i),
    .dmi_wr_i         (dmi_wr_i),
    .dmi_wdata_i      (dmi_wdata_i),
    .dmi_resp_valid_o (dmi_resp_valid_o),
    .dmi_rdata_o      (dmi_rdata_o),
    .dbg_haltreq_o    (dbg_haltreq_o),
    .dbg_resumereq_o  (dbg_resumereq_o),
    .ndmreset_o       (ndmreset_o),
    .core_halted_i    (core_halted_i),
    .core_running_i   (core_running_i),
    .core_resumeack_i (core_resumeack_i),
    .dbg_ar_en_o      (dbg_ar_en_o),
    .dbg_ar_wr_o      (dbg_ar_wr_o),
    .dbg_ar_ad_o      (dbg_ar_ad_o),
    .dbg_ar_do_o      (dbg_ar_do_o),
    .dbg_ar_di_i      (dbg_ar_di_i)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state (debug module as seen by a debugger)
  logic        m_act, m_h, m_r, m_nd;
  logic        m_hpend, m_rpend, m_sticky;
  logic [31:0] m_data0;
  logic [2:0]  m_cmderr;
  logic        m_exec, m_exwr;
  logic [15:0] m_exreg;

  logic        di_force_en = 1'b0;
  logic [31:0] di_force = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_h = 0; m_r = 0; m_nd = 0;
    m_hpend = 0; m_rpend = 0; m_sticky = 0;
    m_data0 = '0; m_cmderr = '0;
    m_exec = 0; m_exwr = 0; m_exreg = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [6:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      7'h04: v = m_data0;
      7'h10: begin v[31] = m_h; v[30] = m_r; v[1] = m_nd; v[0] = m_act; end
      7'h11: begin
        v[3:0] = 4'd2; v[7] = 1'b1;
        v[8] = core_halted_i; v[9] = core_halted_i;
        v[10] = core_running_i; v[11] = core_running_i;
        v[16] = m_sticky; v[17] = m_sticky;
      end
      7'h16: begin v[3:0] = 4'd1; v[10:8] = m_cmderr; v[12] = m_exec; end
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_step(input logic req, input logic [6:0] a, input logic w,
                            input logic [31:0] d, input logic [31:0] di);
    logic wdmc, nexec;
    wdmc  = req && w && (a == 7'h10);
    nexec = 1'b0;
    if (wdmc ? !d[0] : !m_act) begin
      model_reset();
      return;
    end
    if (m_exec && !m_exwr) m_data0 = di;
    if (wdmc) begin m_h = d[31]; m_r = d[30]; m_nd = d[1]; m_act = 1'b1; end
    // halt/resume handshake
    if (m_hpend) begin
      if (core_halted_i || (wdmc && !d[31])) m_hpend = 1'b0;
    end else if (m_rpend) begin
      if (core_resumeack_i) begin m_rpend = 1'b0; m_sticky = 1'b1; end
    end else if (wdmc) begin
      if (d[31] && !core_halted_i) m_hpend = 1'b1;
      else if (!d[31] && d[30] && core_halted_i) begin m_rpend = 1'b1; m_sticky = 1'b0; end
    end
    // abstract command engine
    if (req && w && (a == 7'h04 || a == 7'h16 || a == 7'h17)) begin
      if (m_exec) begin
        if (m_cmderr == 3'd0) m_cmderr = 3'd1;
      end else if (a == 7'h04) begin
        m_data0 = d;
      end else if (a == 7'h16) begin
        m_cmderr = m_cmderr & ~d[10:8];
      end else if (m_cmderr == 3'd0) begin
        if (d[31:24] != 8'd0 || d[22:20] != 3'd2) m_cmderr = 3'd2;
        else if (!core_halted_i) m_cmderr = 3'd4;
        else if (d[17]) begin nexec = 1'b1; m_exwr = d[16]; m_exreg = d[15:0]; end
      end
    end
    m_exec = nexec;
  endtask

  // One clock cycle: check levels, drive inputs, predict, advance.
  task automatic tick(input logic req, input logic [6:0] a, input logic w,
                      input logic [31:0] d, input logic force_exp, input logic [31:0] exp_val);
    exp_t e;
    chk("dbg_haltreq", {31'b0, dbg_haltreq_o}, {31'b0, m_hpend});
    chk("dbg_resumereq", {31'b0, dbg_resumereq_o}, {31'b0, m_rpend});
    chk("ndmreset", {31'b0, ndmreset_o}, {31'b0, m_nd});
    chk("ar_en", {31'b0, dbg_ar_en_o}, {31'b0, m_exec});
    if (m_exec) begin
      chk("ar_wr", {31'b0, dbg_ar_wr_o}, {31'b0, m_exwr});
      chk("ar_ad", {16'b0, dbg_ar_ad_o}, {16'b0, m_exreg});
      chk("ar_do", dbg_ar_do_o, m_data0);
    end else begin
      chk("ar_wr_idle", {31'b0, dbg_ar_wr_o}, 32'd0);
    end
    dbg_ar_di_i     = di_force_en ? di_force : $urandom;
    dmi_req_valid_i = req;
    dmi_addr_i      = a;
    dmi_wr_i        = w;
    dmi_wdata_i     = d;
    if (req) begin
      e.due  = cyc + 1;
      e.data = w ? 32'd0 : (force_exp ? exp_val : model_read(a));
      exp_q.push_back(e);
    end
    model_step(req, a, w, d, dbg_ar_di_i);
    @(negedge clk);
    dmi_req_valid_i = 1'b0;
  endtask

  task automatic idle();
    tick(1'b0, 7'h00, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask
  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    tick(1'b1, a, 1'b1, d, 1'b0, 32'd0);
  endtask
  task automatic rd(input logic [6:0] a);
    tick(1'b1, a, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask
  task automatic rdx(input logic [6:0] a, input logic [31:0] exp_val);
    tick(1'b1, a, 1'b0, 32'd0, 1'b1, exp_val);
  endtask

  // Response monitor: each request must be answered exactly one cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (dmi_resp_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", {31'b0, dmi_resp_valid_o}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_latency", cyc, e.due);
          chk("dmi_rdata", dmi_rdata_o, e.data);
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        chk("resp_missing", {31'b0, dmi_resp_valid_o}, 32'd1);
      end
    end
  end

  initial begin
    logic [6:0]  addrs[5];
    logic [6:0]  a;
    logic [31:0] d;
    int          cnt;
    addrs = '{7'h04, 7'h10, 7'h11, 7'h16, 7'h17};

    reset_i = 1'b1;
    dmi_req_valid_i = 0; dmi_addr_i = '0; dmi_wr_i = 0; dmi_wdata_i = '0;
    core_halted_i = 0; core_running_i = 1; core_resumeack_i = 0;
    dbg_ar_di_i = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", {31'b0, dmi_resp_valid_o}, 32'd0);
    chk("rst_rdata", dmi_rdata_o, 32'd0);
    chk("rst_haltreq", {31'b0, dbg_haltreq_o}, 32'd0);
    chk("rst_resumereq", {31'b0, dbg_resumereq_o}, 32'd0);
    chk("rst_ndmreset", {31'b0, ndmreset_o}, 32'd0);
    chk("rst_ar_en", {31'b0, dbg_ar_en_o}, 32'd0);
    chk("rst_ar_wr", {31'b0, dbg_ar_wr_o}, 32'd0);
    chk("rst_ar_ad", {16'b0, dbg_ar_ad_o}, 32'd0);
    chk("rst_ar_do", dbg_ar_do_o, 32'd0);
    reset_i = 1'b0;
    idle();
    rdx(7'h10, 32'h0);
    rdx(7'h04, 32'h0);

    // Halt request held until the core reports halted 5 cycles later
    wr(7'h10, 32'h80000001);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (dbg_haltreq_o) cnt++;
      if (k == 4) begin core_halted_i = 1; core_running_i = 0; end
      idle();
    end
    chk("haltreq_cycles", cnt, 5);
    rdx(7'h11, 32'h00000382);
    rdx(7'h10, 32'h80000001);

    // Resume handshake
    wr(7'h10, 32'h40000001);
    idle(); idle();
    chk("resumereq_high", {31'b0, dbg_resumereq_o}, 32'd1);
    core_resumeack_i = 1;
    idle();
    core_resumeack_i = 0;
    chk("resumereq_dropped", {31'b0, dbg_resumereq_o}, 32'd0);
    rdx(7'h11, 32'h00030382);

    // Abstract register write
    wr(7'h04, 32'hDEADBEEF);
    wr(7'h17, 32'h00231000);
    chk("exec_ar_en", {31'b0, dbg_ar_en_o}, 32'd1);
    chk("exec_ar_wr", {31'b0, dbg_ar_wr_o}, 32'd1);
    chk("exec_ar_ad", {16'b0, dbg_ar_ad_o}, 32'h1000);
    chk("exec_ar_do", dbg_ar_do_o, 32'hDEADBEEF);
    idle();
    rdx(7'h16, 32'h00000001);

    // Abstract register read into data0
    wr(7'h17, 32'h00221001);
    di_force_en = 1; di_force = 32'h12345678;
    idle();
    di_force_en = 0;
    rdx(7'h04, 32'h12345678);

    // Command while running -> haltresume error, W1C clear
    core_halted_i = 0; core_running_i = 1;
    wr(7'h17, 32'h00231000);
    chk("running_no_ar_en", {31'b0, dbg_ar_en_o}, 32'd0);
    rdx(7'h16, 32'h00000401);
    wr(7'h16, 32'h00000700);
    rdx(7'h16, 32'h00000001);

    // Unsupported size; later commands ignored until cleared
    core_halted_i = 1; core_running_i = 0;
    wr(7'h17, 32'h00331000);
    rdx(7'h16, 32'h00000201);
    wr(7'h17, 32'h00231000);
    chk("blocked_no_ar_en", {31'b0, dbg_ar_en_o}, 32'd0);
    rdx(7'h16, 32'h00000201);
    wr(7'h16, 32'h00000700);
    wr(7'h17, 32'h00231000);
    chk("unblocked_ar_en", {31'b0, dbg_ar_en_o}, 32'd1);

    // Access while busy -> busy error
    wr(7'h04, 32'h11111111);
    rdx(7'h16, 32'h00000101);
    rdx(7'h04, 32'h12345678);
    wr(7'h16, 32'h00000700);

    // Reset in the middle of a command
    wr(7'h17, 32'h00231000);
    #2 reset_i = 1'b1;
    #1 chk("reset_abort_ar_en", {31'b0, dbg_ar_en_o}, 32'd0);
    model_reset();
    @(negedge clk);
    reset_i = 1'b0;
    repeat (3) idle();
    rdx(7'h04, 32'h0);
    rdx(7'h10, 32'h0);

    // Randomized traffic
    wr(7'h10, 32'h00000001);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) core_halted_i = ~core_halted_i;
      if ($urandom_range(15) == 0) core_running_i = ~core_running_i;
      core_resumeack_i = ($urandom_range(7) == 0);
      if ($urandom_range(3) == 0) begin
        idle();
      end else begin
        a = ($urandom_range(6) == 0) ? 7'($urandom) : addrs[$urandom_range(4)];
        d = $urandom;
        if (a == 7'h10) begin
          d = d & 32'h3FFFFFFC;
          d[31] = $urandom_range(1); d[30] = $urandom_range(1);
          d[1] = $urandom_range(1); d[0] = ($urandom_range(15) != 0);
        end else if (a == 7'h17) begin
          d = '0;
          d[31:24] = ($urandom_range(7) == 0) ? 8'($urandom) : 8'd0;
          d[22:20] = ($urandom_range(5) == 0) ? 3'($urandom) : 3'd2;
          d[17] = $urandom_range(1); d[16] = $urandom_range(1);
          d[15:0] = 16'($urandom);
        end
        tick(1'b1, a, 1'($urandom_range(1)), d, 1'b0, 32'd0);
      end
    end
    core_resumeack_i = 0;
    repeat (3) idle();
    chk("resp_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/dm_hart_ctrl.md
DM_HART_CTRL -- requirements
Module: dm_hart_ctrl

Interface
REQ-001 SHALL have ports: clk_i  in  1  sole clock; reset_i  in  1  asynchronous active-high reset.
REQ-002 SHALL have ports: dmi_req_valid_i  in  1  one-cycle DMI request strobe; dmi_addr_i  in  7  DM register address; dmi_wr_i  in  1  1=write; dmi_wdata_i  in  32  write data.
REQ-003 SHALL have ports: dmi_resp_valid_o  out  1  response strobe; dmi_rdata_o  out  32  read data.
REQ-004 SHALL have ports: dbg_haltreq_o  out  1; dbg_resumereq_o  out  1; ndmreset_o  out  1  system reset request.
REQ-005 SHALL have ports: core_halted_i  in  1; core_running_i  in  1; core_resumeack_i  in  1  (all from the core debug FSM).
REQ-006 SHALL have ports: dbg_ar_en_o  out  1; dbg_ar_wr_o  out  1; dbg_ar_ad_o  out  16  regno; dbg_ar_do_o  out  32  write data; dbg_ar_di_i  in  32  combinational read data, valid while dbg_ar_en_o=1.

Function
REQ-007 Register map SHALL be: data0 0x04, dmcontrol 0x10, dmstatus 0x11, abstractcs 0x16, command 0x17; reads of other addresses SHALL return 0 and writes to them SHALL be ignored.
REQ-008 Each request SHALL get dmi_resp_valid_o exactly 1 cycle later, with dmi_rdata_o holding the read value (0 for writes).
REQ-009 dmcontrol SHALL hold haltreq[31], resumereq[30], ndmreset[1], dmactive[0]; while dmactive=0, all other DM state SHALL be held at reset values; ndmreset_o = ndmreset bit.
REQ-010 Hart FSM states: H_IDLE, H_HALTING, H_RESUMING.
REQ-011 H_IDLE -> H_HALTING on dmcontrol write with haltreq=1 while core_halted_i=0; dbg_haltreq_o=1 while in H_HALTING; -> H_IDLE on first cycle core_halted_i=1 or on a write with haltreq=0.
REQ-012 H_IDLE -> H_RESUMING on dmcontrol write with resumereq=1, haltreq=0, core_halted_i=1; this write SHALL clear resumeack_sticky; dbg_resumereq_o=1 while in H_RESUMING; on core_resumeack_i=1: set resumeack_sticky, -> H_IDLE (resumereq drops next cycle).
REQ-013 A write with haltreq=1 and resumereq=1 SHALL act as haltreq only; resumereq while not halted SHALL be ignored.
REQ-014 dmstatus SHALL read: version[3:0]=2, authenticated[7]=1, anyhalted[8]=allhalted[9]=core_halted_i, anyrunning[10]=allrunning[11]=core_running_i, anyresumeack[16]=allresumeack[17]=resumeack_sticky, others 0.
REQ-015 abstractcs SHALL read: datacount[3:0]=1, cmderr[10:8], busy[12], progbufsize[28:24]=0; writing 1s to cmderr bits SHALL clear them (W1C).
REQ-016 Command FSM states: C_IDLE, C_EXEC; busy=1 exactly while in C_EXEC.
REQ-017 command write decode: cmdtype[31:24], aarsize[22:20], transfer[17], write[16], regno[15:0].
REQ-018 command write in C_IDLE with cmderr=0 SHALL be checked: cmdtype!=0 or aarsize!=2 -> cmderr=2; core_halted_i=0 -> cmderr=4; transfer=0 -> no-op success; else -> C_EXEC next cycle.
REQ-019 In C_EXEC (exactly one cycle): dbg_ar_en_o=1, dbg_ar_wr_o=write, dbg_ar_ad_o=regno, dbg_ar_do_o=data0; if write=0, data0 SHALL capture dbg_ar_di_i at the end of that cycle; then -> C_IDLE.
REQ-020 Outside C_EXEC, dbg_ar_en_o SHALL be 0 and dbg_ar_wr_o 0.
REQ-021 command, data0 or abstractcs write while busy SHALL set cmderr=1 (if 0) and be otherwise ignored; command write with cmderr!=0 SHALL be ignored.
REQ-022 data0 SHALL be read/write via DMI when not busy.

Reset
REQ-023 On reset_i: both FSMs idle, dmcontrol=0, data0=0, cmderr=0, resumeack_sticky=0, all outputs 0.
REQ-024 Reset asserted mid-command SHALL abort it with no dbg_ar_en_o pulse after reset.

Structure
REQ-025 Register addresses, dmstatus/abstractcs bit positions, cmderr codes (0 none,1 busy,2 notsupported,4 haltresume) and FSM enums SHALL live in shared package dm_pkg.
REQ-026 Single module; no sub-module required.

Verification
REQ-027 Write dmcontrol=0x80000001, core_halted_i rises 5 cycles later -> dbg_haltreq_o high 5 cycles then low; dmstatus bit 9=1.
REQ-028 Halted; write dmcontrol=0x40000001, resumeack after 3 cycles -> dbg_resumereq_o low next cycle, dmstatus[17]=1.
REQ-029 Halted; data0=0xDEADBEEF, command=0x00231000 -> one-cycle ar_en, wr=1, ad=0x1000, do=0xDEADBEEF; abstractcs busy=0, cmderr=0 after.
REQ-030 Halted; command=0x00221001, dbg_ar_di_i=0x12345678 -> data0 reads 0x12345678.
REQ-031 Running; command=0x00231000 -> no ar_en, cmderr=4; write abstractcs=0x00000700 -> cmderr=0.
REQ-032 command=0x00331000 -> cmderr=2; next command ignored until cleared.
